// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage of the in-order RV32I pipeline. One 32-bit
// little-endian instruction is fetched as four byte reads from the shared
// byte-wide memory port. The bytes are assembled and presented to the IF/ID
// register as {if_pc, if_inst} under a valid/stall handshake.
//
// Ports
//   clk      in   1  clock; all state updates on posedge
//   rst      in   1  synchronous reset, active-high
//   br_pc    in  32  redirect target PC from ID/EX
//   br_e     in   1  redirect enable
//   stl_mm   in   1  MEM stage owns the memory port this cycle
//   stl_id   in   1  IF/ID cannot accept this cycle
//   mem_din  in   8  read data byte, returned one cycle after the address
//   mem_a    out 32  byte address (combinational from state)
//   mem_rd   out  1  read request (combinational from state)
//   if_pc    out 32  PC of the presented instruction
//   if_inst  out 32  presented instruction
//   if_v     out  1  if_pc/if_inst valid
//   stl_if   out  1  high whenever no instruction is available
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] br_pc,
  input  logic        br_e,
  input  logic        stl_mm,
  input  logic        stl_id,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_rd,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_v,
  output logic        stl_if
);

  // F0..F3 issue byte reads pc+0..pc+3; F4 collects the last byte; H holds
  // the assembled instruction until IF/ID takes it.
  typedef enum logic [2:0] {
    F0 = 3'd0,
    F1 = 3'd1,
    F2 = 3'd2,
    F3 = 3'd3,
    F4 = 3'd4,
    H  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [7:0]  byte2_q, byte2_d;
  logic [31:0] ifPc_q, ifPc_d;
  logic [31:0] ifInst_q, ifInst_d;
  logic        ifValid_q, ifValid_d;

  logic [1:0]  byteOffset;
  logic        issuing;

  // Memory port drive. The address tracks the byte being requested in
  // F0..F3 and parks on pc otherwise. The request is suppressed while the
  // MEM stage owns the port and while reset is held, so a stalled cycle
  // never produces a read whose data could be mistaken for ours.
  always_comb begin
    byteOffset = 2'd0;
    issuing    = 1'b0;
    case (state_q)
      F0:      begin byteOffset = 2'd0; issuing = 1'b1; end
      F1:      begin byteOffset = 2'd1; issuing = 1'b1; end
      F2:      begin byteOffset = 2'd2; issuing = 1'b1; end
      F3:      begin byteOffset = 2'd3; issuing = 1'b1; end
      default: begin byteOffset = 2'd0; issuing = 1'b0; end
    endcase
    mem_a  = pc_q + {30'd0, byteOffset};
    mem_rd = issuing & ~stl_mm & ~rst;
  end

  // Next-state logic. A redirect beats a memory stall, which beats normal
  // progress. A redirect drops both the partial word and any instruction
  // being held, even if IF/ID is stalled. A memory stall throws the fetch
  // back to F0 without touching pc, because the byte arriving next cycle
  // belongs to the MEM stage's access, not ours; in H there is nothing in
  // flight, so the stall is ignored there.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    byte0_d   = byte0_q;
    byte1_d   = byte1_q;
    byte2_d   = byte2_q;
    ifPc_d    = ifPc_q;
    ifInst_d  = ifInst_q;
    ifValid_d = ifValid_q;

    if (br_e) begin
      pc_d      = br_pc & 32'hFFFF_FFFE;
      state_d   = F0;
      ifValid_d = 1'b0;
    end else if (stl_mm && (state_q != H)) begin
      state_d = F0;
    end else begin
      case (state_q)
        F0: state_d = F1;
        F1: begin
          byte0_d = mem_din;
          state_d = F2;
        end
        F2: begin
          byte1_d = mem_din;
          state_d = F3;
        end
        F3: begin
          byte2_d = mem_din;
          state_d = F4;
        end
        F4: begin
          ifInst_d  = {mem_din, byte2_q, byte1_q, byte0_q};
          ifPc_d    = pc_q;
          ifValid_d = 1'b1;
          pc_d      = pc_q + 32'd4;
          state_d   = H;
        end
        H: begin
          if (!stl_id) begin
            ifValid_d = 1'b0;
            state_d   = F0;
          end
        end
        default: state_d = F0;
      endcase
    end
  end

  // State and output registers. Reset mid-fetch is indistinguishable from
  // power-on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= F0;
      pc_q      <= PC_RESET;
      byte0_q   <= 8'd0;
      byte1_q   <= 8'd0;
      byte2_q   <= 8'd0;
      ifPc_q    <= 32'd0;
      ifInst_q  <= 32'd0;
      ifValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      byte0_q   <= byte0_d;
      byte1_q   <= byte1_d;
      byte2_q   <= byte2_d;
      ifPc_q    <= ifPc_d;
      ifInst_q  <= ifInst_d;
      ifValid_q <= ifValid_d;
    end
  end

  assign if_pc   = ifPc_q;
  assign if_inst = ifInst_q;
  assign if_v    = ifValid_q;
  assign stl_if  = ~ifValid_q;

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the in-order RV32I pipeline.
- Reads one 32-bit little-endian instruction per fetch from the shared byte-wide memory port: four byte reads, then assembly.
- Presents {pc, inst} to the IF/ID register through a valid/stall handshake.
- Accepts branch/jump redirects from the ID/EX register (target PC plus enable), and yields the memory port whenever the MEM stage owns it.

Parameters:
PC_RESET, 32'h0, PC loaded on reset.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous reset, active-high.
br_pc  in  32  redirect target PC from ID/EX.
br_e  in  1  redirect enable; sampled on posedge.
stl_mm  in  1  MEM stage owns the memory port this cycle.
stl_id  in  1  downstream IF/ID cannot accept this cycle.
mem_din  in  8  read data byte; returns one cycle after the address.
mem_a  out  32  byte address, combinational from state.
mem_rd  out  1  read request, combinational from state.
if_pc  out  32  PC of the presented instruction.
if_inst  out  32  presented instruction.
if_v  out  1  if_pc/if_inst valid.
stl_if  out  1  high whenever if_v=0, i.e. no instruction is available.

Behaviour:
- State register, one-hot or binary: F0, F1, F2, F3, F4, H.
- Internal registers: pc[31:0] and bytes b0, b1, b2.
- Reset (rst=1 at posedge):
  - state<=F0, pc<=PC_RESET, b0..b2<=0.
  - if_pc<=0, if_inst<=0, if_v<=0.
  - While rst=1, mem_rd is forced to 0.
- Combinational outputs:
  - In Fk with k=0..3: mem_a=pc+k, mem_rd=~stl_mm.
  - In F4 and H: mem_rd=0 and mem_a=pc.
- Address arithmetic is 32-bit modulo; pc+k may wrap past 32'hFFFFFFFF.
- Per-edge priority: rst > br_e > stl_mm > normal.
- br_e=1:
  - pc<={br_pc[31:1],1'b0}, state<=F0, if_v<=0.
  - Bytes already captured are discarded.
  - Any held instruction is dropped, even if stl_id=1.
- stl_mm=1 in F0..F4:
  - state<=F0; pc and bytes are unchanged, so the current fetch restarts from byte 0 after the stall.
  - mem_din is not captured on this edge.
- stl_mm=1 in H: no effect; state stays H and if_v is held.
- Normal transitions:
  - F0 -> F1.
  - F1: b0<=mem_din, -> F2.
  - F2: b1<=mem_din, -> F3.
  - F3: b2<=mem_din, -> F4.
  - F4: if_inst<={mem_din,b2,b1,b0}, if_pc<=pc, if_v<=1, pc<=pc+4, -> H.
  - H with stl_id=0: the instruction is consumed on this edge; if_v<=0, -> F0.
  - H with stl_id=1: hold everything.
- Latency and throughput:
  - Redirect/reset edge to if_v=1 is 5 cycles with no stalls.
  - Steady-state issue is one instruction per 6 cycles with stl_id=0.
- if_pc and if_inst only change on the F4 edge; they are stable for the whole time if_v=1.
- Simultaneous br_e and stl_mm: the redirect wins; the next fetch starts at the new PC once stl_mm=0.
- Simultaneous br_e with F4 completion: the completed word is discarded and if_v stays 0.
- Reset mid-fetch: identical to the power-on reset values.

Test Plan:
1. Reset, PC_RESET=0; memory bytes 0..3 = 13,05,A0,00; stl_mm=stl_id=0.
   - mem_a sequence 0,1,2,3 with mem_rd=1.
   - if_v=1 on cycle 5 with if_pc=0 and if_inst=32'h00A00513.
   - The next fetch issues mem_a=4 on cycle 6.
2. Hold in H with stl_id=1 for 3 cycles, then release.
   - if_v, if_pc and if_inst stay constant throughout; mem_rd=0.
   - if_v drops 1 cycle after release, and the fetch at pc=4 starts.
3. stl_mm pulse in F2, one cycle, during the fetch at pc=8.
   - mem_rd=0 that cycle; the fetch restarts at mem_a=8.
   - The instruction is assembled correctly; total latency = 5 + 3 cycles.
4. br_e=1 with br_pc=32'h00000105 during F3.
   - The partial word is discarded; the next mem_a is 0x104.
   - if_pc=0x104 when if_v rises.
5. br_e=1 while in H with stl_id=1.
   - if_v drops on the next cycle, and the fetch restarts at the target.
   - Simultaneously assert stl_mm: no mem_rd until stl_mm=0.
6. Wrap case: br_pc=32'hFFFFFFFE.
   - mem_a sequence FFFFFFFE, FFFFFFFF, 0, 1.
   - if_pc=FFFFFFFE, and the next pc=0x00000002.
   - Assert rst in F2: all outputs return to their reset values on the next cycle.
